// File: rtl/diff_add_mul_pkg.sv
// rtl/diff_add_mul_pkg.sv - shared types, opcodes and result saturation for diff_add_mul_seq
package diff_add_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_MUL = 1'b0;

    // Reduce a wide intermediate to width bits: wrap, or clamp to all-ones
    // when any bit above width-1 is set. Callers zero-extend into 64 bits
    // and slice the low width bits of the return value.
    function automatic logic [63:0] sat_trunc(input logic [63:0] value,
                                              input int          width,
                                              input bit          sat);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        if (sat && ((value & ~mask) != 64'd0)) begin
            return mask;
        end
        return value & mask;
    endfunction

endpackage

// File: rtl/diff_add_mul_seq_if.sv
// rtl/diff_add_mul_seq_if.sv - operand/result handshake bundle for diff_add_mul_seq
// master: operand source and result consumer; slave: the datapath block.
interface diff_add_mul_seq_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] i;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             operation;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] vo;
    logic             out_sign;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output i, j, k, operation, in_valid, out_ready,
        input  in_ready, vo, out_sign, out_valid
    );

    modport slave (
        input  i, j, k, operation, in_valid, out_ready,
        output in_ready, vo, out_sign, out_valid
    );
endinterface

// File: rtl/seq_shift_add_mul.sv
// rtl/seq_shift_add_mul.sv - iterative shift-add multiplier with leading-zero early exit
// Ports: clk, rst (async active-low), start (load d/k), d, k (WIDTH operands),
//        product (2*WIDTH, accumulator value after the current step), last
//        (the current edge is the final step).
module seq_shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   d,
    input  logic [WIDTH-1:0]   k,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplr;
    logic               busy;

    // A non-zero multiplier is the only busy indicator; stepping stops by
    // itself once the remaining multiplier bits are exhausted.
    assign busy    = (mplr != '0);
    // Look-ahead of acc so the owner can register the final product on the
    // same edge as the last step.
    assign product = acc + (mplr[0] ? mcand : '0);
    assign last    = busy && (mplr[WIDTH-1:1] == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
        end else if (start) begin
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, d};
            mplr  <= k;
        end else if (busy) begin
            acc   <= product;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
        end
    end
endmodule

// File: rtl/diff_add_mul_seq.sv
// rtl/diff_add_mul_seq.sv - handshaked |i-j| then add-or-multiply by k, optional saturation
// Ports: clk, rst (async active-low), bus (slave): i, j, k, operation
//        (1 add / 0 multiply), in_valid/in_ready operand handshake,
//        vo/out_sign result with out_valid/out_ready back-pressure.
module diff_add_mul_seq
    import diff_add_mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    diff_add_mul_seq_if.slave   bus
);
    state_t             state, state_n;
    logic [WIDTH:0]     diff_w;
    logic               borrow;
    logic [WIDTH-1:0]   d_abs;
    logic [WIDTH:0]     sum_w;
    logic [WIDTH-1:0]   add_res;
    logic [WIDTH-1:0]   mul_res;
    logic [2*WIDTH-1:0] product;
    logic               mul_last;
    logic               accept;
    logic               start_mul;
    logic               load_out;
    logic [WIDTH-1:0]   vo_n;
    logic               sign_n;
    logic [WIDTH-1:0]   vo_q;
    logic               out_sign_q;
    logic               pend_sign;

    assign diff_w  = {1'b0, bus.i} - {1'b0, bus.j};
    assign borrow  = diff_w[WIDTH];
    assign d_abs   = borrow ? WIDTH'(-diff_w) : diff_w[WIDTH-1:0];
    assign sum_w   = {1'b0, d_abs} + {1'b0, bus.k};
    assign add_res = WIDTH'(sat_trunc(64'(sum_w), WIDTH, SAT));
    assign mul_res = WIDTH'(sat_trunc(64'(product), WIDTH, SAT));

    // Depends on state and out_ready only, never on in_valid.
    assign bus.in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    // A zero multiplier skips the engine and finishes like an add.
    assign start_mul    = accept && (bus.operation == OP_MUL) && (bus.k != '0);

    seq_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (start_mul),
        .d       (d_abs),
        .k       (bus.k),
        .product (product),
        .last    (mul_last)
    );

    always_comb begin
        state_n  = state;
        load_out = 1'b0;
        vo_n     = vo_q;
        sign_n   = out_sign_q;
        unique case (state)
            IDLE, DONE: begin
                if ((state == DONE) && bus.out_ready) begin
                    state_n = IDLE;
                end
                if (accept) begin
                    if (start_mul) begin
                        state_n = MUL;
                    end else begin
                        state_n  = DONE;
                        load_out = 1'b1;
                        vo_n     = (bus.operation == OP_ADD) ? add_res : '0;
                        sign_n   = borrow;
                    end
                end
            end
            MUL: begin
                if (mul_last) begin
                    state_n  = DONE;
                    load_out = 1'b1;
                    vo_n     = mul_res;
                    sign_n   = pend_sign;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            vo_q       <= '0;
            out_sign_q <= 1'b0;
            pend_sign  <= 1'b0;
        end else begin
            state <= state_n;
            if (load_out) begin
                vo_q       <= vo_n;
                out_sign_q <= sign_n;
            end
            if (accept) begin
                pend_sign <= borrow;
            end
        end
    end

    assign bus.vo        = vo_q;
    assign bus.out_sign  = out_sign_q;
    assign bus.out_valid = (state == DONE);
endmodule

// File: tb/tb_diff_add_mul_seq.sv
// tb/tb_diff_add_mul_seq.sv - scoreboard bench for diff_add_mul_seq (wrap and saturate instances)
module tb_diff_add_mul_seq;
    import diff_add_mul_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] vo0;
        logic [W-1:0] vo1;
        logic         sign;
        int           lat;
        int           acc_cyc;
        string        name;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst;
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    exp_t  q[$];
    bit    stamped = 1'b0;
    int    first_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    diff_add_mul_seq_if #(.WIDTH(W)) bus0 ();
    diff_add_mul_seq_if #(.WIDTH(W)) bus1 ();

    assign bus1.i         = bus0.i;
    assign bus1.j         = bus0.j;
    assign bus1.k         = bus0.k;
    assign bus1.operation = bus0.operation;
    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.out_ready = bus0.out_ready;

    diff_add_mul_seq #(.WIDTH(W), .SAT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    diff_add_mul_seq #(.WIDTH(W), .SAT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input string name, input logic [W-1:0] i, input logic [W-1:0] j,
                         input logic [W-1:0] k, input logic op, input logic [W-1:0] e0,
                         input logic [W-1:0] e1, input logic es, input int lat, input bit push);
        bit got = 1'b0;
        bus0.i         = i;
        bus0.j         = j;
        bus0.k         = k;
        bus0.operation = op;
        bus0.in_valid  = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (bus0.in_ready) got = 1'b1;
        end
        if (!got) begin
            check({name, "_accept_timeout"}, 32'd0, 32'd1);
        end else if (push) begin
            q.push_back('{e0, e1, es, lat, cyc + 1, name});
        end
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 40 && q.size() != 0; n++) begin
            @(negedge clk);
        end
        check({name, "_pending"}, q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: stamps the first cycle a result is visible, pops on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus0.out_valid && !stamped) begin
                stamped   = 1'b1;
                first_cyc = cyc;
            end
            if (bus0.out_valid && bus0.out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got vo=%0d expected none", bus0.vo);
                end else begin
                    e = q.pop_front();
                    check({e.name, "_vo"},     bus0.vo,       e.vo0);
                    check({e.name, "_vo_sat"}, bus1.vo,       e.vo1);
                    check({e.name, "_sign"},   bus0.out_sign, e.sign);
                    check({e.name, "_lat"},    first_cyc - e.acc_cyc + 1, e.lat);
                end
                stamped = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst            = 1'b0;
        bus0.i         = '0;
        bus0.j         = '0;
        bus0.k         = '0;
        bus0.operation = OP_ADD;
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus0.out_valid, 32'd0);
        check("rst_vo",        bus0.vo,        32'd0);
        check("rst_sign",      bus0.out_sign,  32'd0);
        check("rst_in_ready",  bus0.in_ready,  32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        issue("add_basic", 8'd10, 8'd3, 8'd5, OP_ADD, 8'd12, 8'd12, 1'b0, 1, 1'b1);
        issue("mul_sign", 8'd3, 8'd10, 8'd6, OP_MUL, 8'd42, 8'd42, 1'b1, 4, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("mul_busy_in_ready", bus0.in_ready, 32'd0);
        end
        @(posedge clk);
        #1;
        issue("add_ovf",  8'd200, 8'd0,   8'd100, OP_ADD, 8'd44,  8'd255, 1'b0, 1, 1'b1);
        issue("mul_max",  8'd255, 8'd0,   8'd255, OP_MUL, 8'd1,   8'd255, 1'b0, 9, 1'b1);
        issue("mul_k0",   8'd9,   8'd4,   8'd0,   OP_MUL, 8'd0,   8'd0,   1'b0, 1, 1'b1);
        issue("mul_d0",   8'd4,   8'd4,   8'd9,   OP_MUL, 8'd0,   8'd0,   1'b0, 5, 1'b1);
        issue("add_neg",  8'd0,   8'd255, 8'd255, OP_ADD, 8'd254, 8'd255, 1'b1, 1, 1'b1);
        issue("add_b2b",  8'd7,   8'd2,   8'd1,   OP_ADD, 8'd6,   8'd6,   1'b0, 1, 1'b1);
        drain("seq");

        // Back-pressure: result held five cycles, then retired alongside a new accept.
        bus0.out_ready = 1'b0;
        issue("bp_hold", 8'd5, 8'd9, 8'd3, OP_ADD, 8'd7, 8'd7, 1'b1, 1, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", bus0.out_valid, 32'd1);
            check("bp_vo",        bus0.vo,        32'd7);
            check("bp_in_ready",  bus0.in_ready,  32'd0);
        end
        @(posedge clk);
        #1;
        bus0.out_ready = 1'b1;
        issue("bp_next", 8'd1, 8'd1, 8'd200, OP_ADD, 8'd200, 8'd200, 1'b0, 1, 1'b1);
        drain("bp");

        // Reset in the middle of a multiply: no output may follow.
        issue("rst_mul", 8'd0, 8'd255, 8'd128, OP_MUL, 8'd0, 8'd0, 1'b1, 9, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", bus0.out_valid, 32'd0);
        check("midrst_vo",        bus0.vo,        32'd0);
        check("midrst_vo_sat",    bus1.vo,        32'd0);
        check("midrst_in_ready",  bus0.in_ready,  32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_out_valid", bus0.out_valid, 32'd0);
        @(posedge clk);
        #1;
        issue("post_rst_mul", 8'd20, 8'd5, 8'd3, OP_MUL, 8'd45, 8'd45, 1'b0, 3, 1'b1);
        drain("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
